goertzel_tone_detect: RTL and testbench
=======================================

# goertzel_tone_detect

Consumer-side block for the Goertzel filter. Accepts each one-cycle result strobe with signed Re{X(k)}/Im{X(k)}, computes the bin power |X(k)|² with a serial shift-add squarer, and applies a two-threshold hysteresis with consecutive-block debounce. Produces a registered tone-present flag. Sits directly after `goertzel_IIR`. Its output drives the LED or control logic in place of the raw `o_data_valid`.

## Interface
Parameters:
- `IW`, 18: width of the signed Re/Im inputs; matches the Goertzel `OW`.
- `PW`, 2*IW: unsigned power width; holds the worst case 2^(2·IW−1) exactly.
- `HITS`, 3: consecutive blocks at or above `i_thresh_on` needed to assert the tone.
- `MISSES`, 3: consecutive blocks below `i_thresh_off` needed to deassert the tone.

Ports:
- `i_clk`  in  1: single clock.
- `i_rst_n`  in  1: synchronous, active-low reset.
- `i_data_valid`  in  1: one-cycle strobe from the Goertzel `o_data_valid`.
- `i_result_re`  in  IW: Re{X(k)}, signed two's complement.
- `i_result_im`  in  IW: Im{X(k)}, signed two's complement.
- `i_thresh_on`  in  PW: assert threshold, unsigned.
- `i_thresh_off`  in  PW: release threshold, unsigned.
- `o_busy`  out  1: high whenever the state is not IDLE.
- `o_power_valid`  out  1: one-cycle strobe qualifying `o_power`.
- `o_power`  out  PW: Re² + Im², unsigned; holds its value between strobes.
- `o_tone`  out  1: debounced tone-present flag.
- `o_overrun`  out  1: sticky; a strobe arrived while busy.

## Operation
- States: IDLE → SQ_RE → SQ_IM → DECIDE → IDLE.
- **IDLE**
  - When `i_data_valid`=1, latch |re| and |im| as IW-bit unsigned values.
  - The most negative input maps to 2^(IW−1) with no saturation.
  - Clear the accumulator and go to SQ_RE.
- **SQ_RE**
  - IW cycles, one multiplier bit per cycle, LSB first.
  - Each cycle: if the current bit of |re| is 1, add |re| << bit to the PW-bit accumulator.
  - No truncation anywhere in the datapath.
- **SQ_IM**
  - IW cycles, same procedure on |im|, adding into the same accumulator.
- **DECIDE**, one cycle:
  - Register `o_power` ← accumulator and pulse `o_power_valid`.
  - Sample the thresholds in this cycle and compare against the accumulator value:
    - If power ≥ `i_thresh_on`: hit_cnt+1 (saturating at HITS) and miss_cnt ← 0.
    - Else if power < `i_thresh_off`: miss_cnt+1 (saturating at MISSES) and hit_cnt ← 0.
    - Otherwise: both counters ← 0 and `o_tone` holds.
  - `o_tone` ← 1 when the updated hit_cnt == HITS; `o_tone` ← 0 when the updated miss_cnt == MISSES.
  - The on-check has priority when `i_thresh_off` > `i_thresh_on`.
- **Overrun**
  - `i_data_valid` seen while not in IDLE, including in DECIDE, is dropped.
  - A dropped strobe sets `o_overrun`. Only reset clears it.
- **Reset**
  - `i_rst_n`=0 at any clock edge: state ← IDLE, counters ← 0.
  - All outputs ← 0, including `o_power`.
  - Reset mid-computation aborts it; no `o_power_valid` is produced.

## Timing
- The strobe is sampled at edge E0. SQ_RE covers edges E1..E_IW and SQ_IM covers E_IW+1..E_2IW. DECIDE registers the result at E_2IW+1.
- `o_power_valid` is high for exactly one cycle, 2·IW+1 cycles after the strobe cycle. With IW=18 that is 37 cycles.
- `o_busy` rises the cycle after the accepted strobe and falls together with `o_power_valid`.
- A new strobe is accepted in the same cycle that `o_power_valid` is high, since the state is IDLE again.
- `o_tone` changes only in the same cycle that `o_power_valid` is high.
- Minimum strobe spacing is 2·IW+2 cycles. Goertzel spacing of N=126 samples meets this with margin.

## Structure
- A shared package `goertzel_pkg` holds:
  - the state encoding localparams (IDLE=0, SQ_RE=1, SQ_IM=2, DECIDE=3);
  - the default IW/PW;
  - the counter-width function clog2(max(HITS,MISSES)+1).
- One sub-module, `serial_sq_acc`:
  - load, step, bit index, IW-bit operand, and PW-bit accumulator with clear;
  - the FSM and hysteresis logic live in the top module.

## Test plan
- **Basic power**, IW=18: re=3, im=−4 → `o_power_valid` exactly 37 cycles after the strobe; `o_power`=25; `o_busy` high for 37 cycles.
- **Extremes**: re=−131072, im=−131072 → `o_power`=34359738368 (2^35), with no overflow. Then re=0, im=0 → `o_power`=0.
- **Hysteresis**: thresh_on=1000, thresh_off=500, HITS=MISSES=3, strobes every 126 cycles.
  - Three blocks with re=40, im=0 (power 1600): `o_tone` rises on the third `o_power_valid`.
  - Two blocks with re=26 (power 676): `o_tone` stays 1.
  - Then re=10 (power 100) ×3: `o_tone` falls on the third.
  - Then re=10 ×2 followed by re=40: `o_tone` stays 0 because the counters reset.
- **Overrun**: second strobe 10 cycles after the first → exactly one `o_power_valid`; `o_overrun`=1 and stays 1 through later normal blocks.
  - A strobe landing in the same cycle as `o_power_valid` is accepted, and `o_overrun` is not set.
- **Reset mid-op**: `i_rst_n`=0 for one cycle at 20 cycles after a strobe → no `o_power_valid`; next cycle `o_power`=0, `o_tone`=0, `o_busy`=0, `o_overrun`=0. The next strobe is processed normally.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared definitions for the Goertzel tone-detect consumer: state encoding,
// default widths and the hysteresis counter width helper.
package goertzel_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SQ_RE  = 2'd1;
    localparam logic [1:0] ST_SQ_IM  = 2'd2;
    localparam logic [1:0] ST_DECIDE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SQ_RE  = ST_SQ_RE,
        SQ_IM  = ST_SQ_IM,
        DECIDE = ST_DECIDE
    } state_e;

    localparam int DEFAULT_IW = 18;
    localparam int DEFAULT_PW = 2 * DEFAULT_IW;

    // Bits needed to count up to the larger of the two debounce limits.
    function automatic int cnt_width(input int hits, input int misses);
        int m;
        m = (hits > misses) ? hits : misses;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/serial_sq_acc.sv
// Serial shift-add squarer: one multiplier bit per step, LSB first, summed
// into a full-width accumulator shared by consecutive operands.
module serial_sq_acc
    import goertzel_pkg::*;
#(
    parameter int IW = DEFAULT_IW,
    parameter int PW = DEFAULT_PW,
    parameter int BW = $clog2(IW)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [IW-1:0] i_load_val,
    input  logic          i_step,
    input  logic [BW-1:0] i_bit_idx,
    output logic [PW-1:0] o_acc
);

    logic [IW-1:0] op_q, op_d;
    logic [PW-1:0] acc_q, acc_d;

    // The step uses the operand held before this edge, so a load may coincide
    // with the final step of the previous operand.
    always_comb begin
        op_d  = op_q;
        acc_d = acc_q;
        if (i_load) begin
            op_d = i_load_val;
        end
        if (i_clear) begin
            acc_d = '0;
        end else if (i_step && op_q[i_bit_idx]) begin
            acc_d = acc_q + (PW'(op_q) << i_bit_idx);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            op_q  <= '0;
            acc_q <= '0;
        end else begin
            op_q  <= op_d;
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule

// File: rtl/goertzel_tone_detect.sv
// Goertzel result consumer: serial |X(k)|^2, two-threshold hysteresis with
// consecutive-block debounce, and a sticky overrun flag for dropped strobes.
module goertzel_tone_detect
    import goertzel_pkg::*;
#(
    parameter int IW     = DEFAULT_IW,
    parameter int PW     = 2 * IW,
    parameter int HITS   = 3,
    parameter int MISSES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_data_valid,
    input  logic signed [IW-1:0] i_result_re,
    input  logic signed [IW-1:0] i_result_im,
    input  logic        [PW-1:0] i_thresh_on,
    input  logic        [PW-1:0] i_thresh_off,
    output logic                 o_busy,
    output logic                 o_power_valid,
    output logic        [PW-1:0] o_power,
    output logic                 o_tone,
    output logic                 o_overrun
);

    localparam int BW = $clog2(IW);
    localparam int CW = cnt_width(HITS, MISSES);

    localparam logic [BW-1:0] LAST_BIT = BW'(IW - 1);
    localparam logic [CW-1:0] HITS_C   = CW'(HITS);
    localparam logic [CW-1:0] MISSES_C = CW'(MISSES);

    // Two's-complement magnitude; the most negative value maps to 2^(IW-1).
    function automatic logic [IW-1:0] abs_val(input logic [IW-1:0] x);
        return x[IW-1] ? (~x + 1'b1) : x;
    endfunction

    state_e        state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [IW-1:0] im_abs_q, im_abs_d;
    logic [CW-1:0] hit_q, hit_d;
    logic [CW-1:0] miss_q, miss_d;
    logic          tone_q, tone_d;
    logic [PW-1:0] power_q, power_d;
    logic          power_valid_q, power_valid_d;
    logic          overrun_q, overrun_d;

    logic          sq_clear, sq_load, sq_step;
    logic [IW-1:0] sq_load_val;
    logic [PW-1:0] acc;
    logic [IW-1:0] re_abs, im_abs;

    assign re_abs = abs_val(i_result_re);
    assign im_abs = abs_val(i_result_im);

    serial_sq_acc #(
        .IW (IW),
        .PW (PW),
        .BW (BW)
    ) u_sq (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (sq_clear),
        .i_load     (sq_load),
        .i_load_val (sq_load_val),
        .i_step     (sq_step),
        .i_bit_idx  (bit_q),
        .o_acc      (acc)
    );

    // NOTE: every signal gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        bit_d         = bit_q;
        im_abs_d      = im_abs_q;
        hit_d         = hit_q;
        miss_d        = miss_q;
        tone_d        = tone_q;
        power_d       = power_q;
        power_valid_d = 1'b0;
        overrun_d     = overrun_q | (i_data_valid && (state_q != IDLE));
        sq_clear      = 1'b0;
        sq_load       = 1'b0;
        sq_load_val   = re_abs;
        sq_step       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_data_valid) begin
                    sq_clear    = 1'b1;
                    sq_load     = 1'b1;
                    sq_load_val = re_abs;
                    im_abs_d    = im_abs;
                    bit_d       = '0;
                    state_d     = SQ_RE;
                end
            end
            SQ_RE: begin
                sq_step = 1'b1;
                if (bit_q == LAST_BIT) begin
                    bit_d       = '0;
                    sq_load     = 1'b1;
                    sq_load_val = im_abs_q;
                    state_d     = SQ_IM;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            SQ_IM: begin
                sq_step = 1'b1;
                if (bit_q == LAST_BIT) begin
                    bit_d   = '0;
                    state_d = DECIDE;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            DECIDE: begin
                power_d       = acc;
                power_valid_d = 1'b1;
                state_d       = IDLE;
                // Checking the on-threshold first gives it priority when the
                // thresholds are inverted.
                if (acc >= i_thresh_on) begin
                    hit_d  = (hit_q == HITS_C) ? hit_q : hit_q + 1'b1;
                    miss_d = '0;
                end else if (acc < i_thresh_off) begin
                    miss_d = (miss_q == MISSES_C) ? miss_q : miss_q + 1'b1;
                    hit_d  = '0;
                end else begin
                    hit_d  = '0;
                    miss_d = '0;
                end
                if (hit_d == HITS_C) begin
                    tone_d = 1'b1;
                end else if (miss_d == MISSES_C) begin
                    tone_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            bit_q         <= '0;
            im_abs_q      <= '0;
            hit_q         <= '0;
            miss_q        <= '0;
            tone_q        <= 1'b0;
            power_q       <= '0;
            power_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_q         <= bit_d;
            im_abs_q      <= im_abs_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            tone_q        <= tone_d;
            power_q       <= power_d;
            power_valid_q <= power_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_power_valid = power_valid_q;
    assign o_power       = power_q;
    assign o_tone        = tone_q;
    assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_goertzel_tone_detect.sv
// Bench for goertzel_tone_detect: a timestamp-based reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_goertzel_tone_detect;

    localparam int IW     = 18;
    localparam int PW     = 2 * IW;
    localparam int HITS   = 3;
    localparam int MISSES = 3;
    localparam int LAT    = 2 * IW + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 dv;
    logic signed [IW-1:0] re, im;
    logic        [PW-1:0] thr_on, thr_off;
    logic                 o_busy, o_power_valid, o_tone, o_overrun;
    logic        [PW-1:0] o_power;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    goertzel_tone_detect #(
        .IW     (IW),
        .PW     (PW),
        .HITS   (HITS),
        .MISSES (MISSES)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_valid  (dv),
        .i_result_re   (re),
        .i_result_im   (im),
        .i_thresh_on   (thr_on),
        .i_thresh_off  (thr_off),
        .o_busy        (o_busy),
        .o_power_valid (o_power_valid),
        .o_power       (o_power),
        .o_tone        (o_tone),
        .o_overrun     (o_overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a block accepted at edge T completes at edge T+LAT;
    // any strobe sampled while a block is pending is dropped and flagged.
    int     cyc = 0;
    bit     m_busy = 0;
    int     m_due = 0;
    longint m_pend = 0;
    longint m_power = 0;
    bit     m_valid = 0;
    bit     m_tone = 0;
    bit     m_over = 0;
    int     m_hit = 0;
    int     m_miss = 0;
    bit     chk_en = 0;

    always @(posedge clk) begin : model
        bit     was_busy;
        longint r, i;
        cyc++;
        if (!rst_n) begin
            m_busy  = 0;
            m_valid = 0;
            m_power = 0;
            m_tone  = 0;
            m_over  = 0;
            m_hit   = 0;
            m_miss  = 0;
        end else begin
            was_busy = m_busy;
            m_valid  = 0;
            if (was_busy && cyc == m_due) begin
                m_valid = 1;
                m_busy  = 0;
                m_power = m_pend;
                if (m_power >= longint'(thr_on)) begin
                    m_hit  = (m_hit < HITS) ? m_hit + 1 : HITS;
                    m_miss = 0;
                end else if (m_power < longint'(thr_off)) begin
                    m_miss = (m_miss < MISSES) ? m_miss + 1 : MISSES;
                    m_hit  = 0;
                end else begin
                    m_hit  = 0;
                    m_miss = 0;
                end
                if (m_hit == HITS) m_tone = 1;
                if (m_miss == MISSES) m_tone = 0;
            end
            if (dv) begin
                if (was_busy) begin
                    m_over = 1;
                end else begin
                    r      = longint'(re);
                    i      = longint'(im);
                    m_pend = r * r + i * i;
                    m_busy = 1;
                    m_due  = cyc + LAT;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", o_busy, m_busy);
            check("cyc_power_valid", o_power_valid, m_valid);
            check("cyc_power", o_power, m_power);
            check("cyc_tone", o_tone, m_tone);
            check("cyc_overrun", o_overrun, m_over);
        end
    end

    task automatic strobe(input int r, input int i);
        @(negedge clk);
        dv = 1'b1;
        re = r[IW-1:0];
        im = i[IW-1:0];
        @(negedge clk);
        dv = 1'b0;
    endtask

    // Called right after a strobe; returns at the negedge where o_power_valid
    // is seen, or after a bounded wait (lat then exceeds LAT).
    task automatic wait_valid(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            busy_cnt += int'(o_busy);
            @(negedge clk);
            lat++;
            if (o_power_valid === 1'b1) return;
        end
    endtask

    task automatic count_valids(input int n, output int nv);
        nv = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_power_valid === 1'b1) nv++;
        end
    endtask

    task automatic gap();
        repeat (88) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int hyst_re   [11] = '{40, 40, 40, 26, 26, 10, 10, 10, 10, 10, 40};
    bit hyst_tone [11] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        int lat, bc, nv;
        rst_n   = 1'b0;
        dv      = 1'b0;
        re      = '0;
        im      = '0;
        thr_on  = PW'(1000);
        thr_off = PW'(500);
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst_n  = 1'b1;
        check("rst_power", o_power, 0);
        check("rst_tone", o_tone, 0);
        check("rst_busy", o_busy, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_valid", o_power_valid, 0);

        // Basic power: 3^2 + 4^2
        strobe(3, -4);
        wait_valid(lat, bc);
        check("basic_latency", lat, 37);
        check("basic_busy_cycles", bc, 37);
        check("basic_power", o_power, 25);
        @(negedge clk);
        check("basic_valid_one_cycle", o_power_valid, 0);
        gap();

        // Extremes
        strobe(-131072, -131072);
        wait_valid(lat, bc);
        check("ext_latency", lat, 37);
        check("ext_power", o_power, 64'd34359738368);
        gap();
        strobe(0, 0);
        wait_valid(lat, bc);
        check("zero_power", o_power, 0);
        gap();

        // Hysteresis and debounce
        for (int k = 0; k < 11; k++) begin
            strobe(hyst_re[k], 0);
            wait_valid(lat, bc);
            check("hyst_latency", lat, 37);
            check("hyst_tone", o_tone, hyst_tone[k]);
            gap();
        end

        // Strobe in the same cycle as o_power_valid is accepted
        strobe(5, 12);
        wait_valid(lat, bc);
        check("b2b_first_power", o_power, 169);
        dv = 1'b1;
        re = -18'sd7;
        im = 18'sd24;
        @(negedge clk);
        dv = 1'b0;
        wait_valid(lat, bc);
        check("b2b_latency", lat, 37);
        check("b2b_second_power", o_power, 625);
        check("b2b_no_overrun", o_overrun, 0);
        gap();

        // Overrun: second strobe ten cycles into the first block
        strobe(1, 1);
        repeat (8) @(negedge clk);
        strobe(2, 2);
        count_valids(120, nv);
        check("ovr_valid_count", nv, 1);
        check("ovr_power", o_power, 2);
        check("ovr_flag", o_overrun, 1);
        strobe(6, 8);
        wait_valid(lat, bc);
        check("ovr_next_power", o_power, 100);
        check("ovr_sticky", o_overrun, 1);
        gap();

        // Reset in the middle of a computation
        strobe(9, 9);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_power", o_power, 0);
        check("midrst_tone", o_tone, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_overrun", o_overrun, 0);
        count_valids(60, nv);
        check("midrst_no_valid", nv, 0);
        strobe(7, -1);
        wait_valid(lat, bc);
        check("after_rst_latency", lat, 37);
        check("after_rst_power", o_power, 50);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
